// File: rtl/hififo_pkg.sv
// Shared constants and the request record used by the hififo request arbiter.
package hififo_pkg;

  localparam int ADDR_W   = 64;
  localparam int TAG_W    = 8;
  localparam int CHAN_W   = 3;
  localparam int NCH_MAX  = 8;
  localparam int NTAG_MAX = 256;

  // One request as presented to the TLP transmit engine.
  typedef struct packed {
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [CHAN_W-1:0] chan;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/hififo_request_arbiter_if.sv
// Bundle of channel request, TX request and completion signals around the
// arbiter. The slave modport is the arbiter's view; master is its surroundings
// (channel controllers, TX engine and completion decoder).
interface hififo_request_arbiter_if #(
  parameter int NCH = 4
);
  import hififo_pkg::*;

  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_is_read;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        req_ready;

  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_is_read;
  logic [ADDR_W-1:0]     tx_addr;
  logic [TAG_W-1:0]      tx_tag;
  logic [CHAN_W-1:0]     tx_chan;

  logic                  cpl_valid;
  logic [TAG_W-1:0]      cpl_tag;
  logic                  cpl_last;
  logic                  cpl_route_valid;
  logic [CHAN_W-1:0]     cpl_route_chan;
  logic [8:0]            tags_free;
  logic                  err_spurious_cpl;

  modport master (
    output req_valid, req_is_read, req_addr, tx_ready, cpl_valid, cpl_tag, cpl_last,
    input  req_ready, tx_valid, tx_is_read, tx_addr, tx_tag, tx_chan,
           cpl_route_valid, cpl_route_chan, tags_free, err_spurious_cpl
  );

  modport slave (
    input  req_valid, req_is_read, req_addr, tx_ready, cpl_valid, cpl_tag, cpl_last,
    output req_ready, tx_valid, tx_is_read, tx_addr, tx_tag, tx_chan,
           cpl_route_valid, cpl_route_chan, tags_free, err_spurious_cpl
  );

endinterface

// File: rtl/hififo_tag_pool.sv
// Read-tag pool: hands out the lowest free tag, remembers which channel owns
// each live tag so completions can be routed back, and frees a tag on its
// final completion. Completions for tags that are not live are flagged and
// otherwise ignored.
module hififo_tag_pool
  import hififo_pkg::*;
#(
  parameter int NTAG = 32
) (
  input  logic              clock,
  input  logic              pci_reset_n,
  input  logic              alloc,
  input  logic [CHAN_W-1:0] alloc_chan,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              any_free,
  input  logic              cpl_valid,
  input  logic [TAG_W-1:0]  cpl_tag,
  input  logic              cpl_last,
  output logic              cpl_route_valid,
  output logic [CHAN_W-1:0] cpl_route_chan,
  output logic [8:0]        tags_free,
  output logic              err_spurious_cpl
);

  localparam int IDX_W = (NTAG > 1) ? $clog2(NTAG) : 1;

  logic [NTAG-1:0]   free_mask;
  logic [NTAG-1:0]   mask_next;
  logic [CHAN_W-1:0] owner [NTAG];
  logic [IDX_W-1:0]  alloc_idx;
  logic [IDX_W-1:0]  cpl_idx;
  logic              cpl_in_range;
  logic              cpl_live;
  logic              do_free;

  assign cpl_in_range = ({1'b0, cpl_tag} < 9'(NTAG));
  assign cpl_idx      = cpl_tag[IDX_W-1:0];
  assign cpl_live     = cpl_in_range && !free_mask[cpl_idx];
  assign do_free      = cpl_valid && cpl_live && cpl_last;
  assign any_free     = |free_mask;
  assign alloc_tag    = TAG_W'(alloc_idx);

  // Find-first-free: scanning downward leaves the lowest free index.
  always_comb begin
    alloc_idx = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Allocation and free never hit the same tag (one is free, one is live).
  always_comb begin
    mask_next = free_mask;
    if (alloc)   mask_next[alloc_idx] = 1'b0;
    if (do_free) mask_next[cpl_idx]   = 1'b1;
  end

  // Free mask and counter; a reset returns every tag to the pool.
  always_ff @(posedge clock or negedge pci_reset_n) begin
    if (!pci_reset_n) begin
      free_mask <= '1;
      tags_free <= 9'(NTAG);
    end else begin
      free_mask <= mask_next;
      tags_free <= tags_free + {8'b0, do_free} - {8'b0, alloc};
    end
  end

  // Owner table needs no reset: an entry is only read while its tag is live.
  always_ff @(posedge clock) begin
    if (alloc) owner[alloc_idx] <= alloc_chan;
  end

  // Registered completion routing and the sticky spurious-completion flag.
  always_ff @(posedge clock or negedge pci_reset_n) begin
    if (!pci_reset_n) begin
      cpl_route_valid  <= 1'b0;
      cpl_route_chan   <= '0;
      err_spurious_cpl <= 1'b0;
    end else begin
      cpl_route_valid <= cpl_valid && cpl_live;
      if (cpl_valid && cpl_live) cpl_route_chan <= owner[cpl_idx];
      if (cpl_valid && !cpl_live) err_spurious_cpl <= 1'b1;
    end
  end

endmodule

// File: rtl/hififo_request_arbiter.sv
// Round-robin arbiter sharing the PCIe TX request port between channel
// controllers. Accepted requests are registered toward the TX engine; reads
// get a tag from the tag pool so their completions can be routed back.
module hififo_request_arbiter
  import hififo_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int NTAG = 32
) (
  input  logic                      clock,
  input  logic                      pci_reset_n,
  hififo_request_arbiter_if.slave   bus
);

  localparam int CIW = $clog2(NCH);

  logic [CIW-1:0]    last_grant;
  logic [CIW-1:0]    grant_idx;
  logic              grant_found;
  logic [NCH-1:0]    eligible;
  logic [ADDR_W-1:0] addr_arr [NCH];
  logic              slot_free;
  logic              take;
  logic              alloc;
  logic              any_free;
  logic [TAG_W-1:0]  alloc_tag;
  logic              tx_valid_q;
  req_t              tx_q;

  assign slot_free = !tx_valid_q || bus.tx_ready;
  assign take      = slot_free && grant_found && pci_reset_n;
  assign alloc     = take && bus.req_is_read[grant_idx];

  // Split the flattened address bus and mark channels that could be served;
  // a read is only eligible while the pool still holds a tag.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      eligible[i] = bus.req_valid[i] && (!bus.req_is_read[i] || any_free);
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [CIW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CIW'((int'(last_grant) + k) % NCH);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot acceptance, suppressed while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (take) bus.req_ready[grant_idx] = 1'b1;
  end

  // Output register and round-robin pointer; payload holds while stalled.
  always_ff @(posedge clock or negedge pci_reset_n) begin
    if (!pci_reset_n) begin
      tx_valid_q <= 1'b0;
      tx_q       <= '0;
      last_grant <= CIW'(NCH - 1);
    end else if (take) begin
      tx_valid_q   <= 1'b1;
      tx_q.is_read <= bus.req_is_read[grant_idx];
      tx_q.addr    <= addr_arr[grant_idx];
      tx_q.chan    <= CHAN_W'(grant_idx);
      tx_q.tag     <= alloc ? alloc_tag : '0;
      last_grant   <= grant_idx;
    end else if (bus.tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_is_read = tx_q.is_read;
  assign bus.tx_addr    = tx_q.addr;
  assign bus.tx_tag     = tx_q.tag;
  assign bus.tx_chan    = tx_q.chan;

  hififo_tag_pool #(
    .NTAG(NTAG)
  ) u_tag_pool (
    .clock            (clock),
    .pci_reset_n      (pci_reset_n),
    .alloc            (alloc),
    .alloc_chan       (CHAN_W'(grant_idx)),
    .alloc_tag        (alloc_tag),
    .any_free         (any_free),
    .cpl_valid        (bus.cpl_valid),
    .cpl_tag          (bus.cpl_tag),
    .cpl_last         (bus.cpl_last),
    .cpl_route_valid  (bus.cpl_route_valid),
    .cpl_route_chan   (bus.cpl_route_chan),
    .tags_free        (bus.tags_free),
    .err_spurious_cpl (bus.err_spurious_cpl)
  );

endmodule

// File: tb/tb_hififo_request_arbiter.sv
// Bench for hififo_request_arbiter: a table of per-cycle vectors plus hand
// sequences for tag exhaustion, completions, spurious tags and reset. A small
// behavioural model predicts grants and queues expected TX records.
module tb_hififo_request_arbiter;
  import hififo_pkg::*;

  localparam int NCH  = 4;
  localparam int NTAG = 32;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] is_read;
    logic       tx_ready;
    logic       cpl_valid;
    logic [7:0] cpl_tag;
    logic       cpl_last;
    logic [3:0] exp_ready;
  } vec_t;

  logic clock = 1'b0;
  logic pci_reset_n;

  hififo_request_arbiter_if #(.NCH(NCH)) bus();

  hififo_request_arbiter #(
    .NCH(NCH),
    .NTAG(NTAG)
  ) dut (
    .clock       (clock),
    .pci_reset_n (pci_reset_n),
    .bus         (bus.slave)
  );

  // 100 MHz style free-running clock.
  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_bad = 0;
  int          m_last;
  bit          m_free [NTAG];
  int          m_owner [NTAG];
  int          m_count;
  bit          m_txv;
  bit          m_err;
  bit          m_rv;
  int          m_rc;
  req_t        exp_q [$];
  logic [63:0] ch_addr [NCH];
  vec_t        tbl [15];
  logic [3:0]  r;

  function automatic vec_t mkv(input logic [3:0] valid, input logic [3:0] rd,
                               input logic rdy, input logic cv, input logic [7:0] tag,
                               input logic last, input logic [3:0] er);
    vec_t v;
    v.valid = valid; v.is_read = rd; v.tx_ready = rdy;
    v.cpl_valid = cv; v.cpl_tag = tag; v.cpl_last = last; v.exp_ready = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = NCH - 1;
    m_count = NTAG;
    m_txv   = 0;
    m_err   = 0;
    m_rv    = 0;
    m_rc    = 0;
    for (int i = 0; i < NTAG; i++) m_free[i] = 1;
    exp_q.delete();
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid   = v.valid;
    bus.req_is_read = v.is_read;
    bus.tx_ready    = v.tx_ready;
    bus.cpl_valid   = v.cpl_valid;
    bus.cpl_tag     = v.cpl_tag;
    bus.cpl_last    = v.cpl_last;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i] = {8'(i + 1), 24'h0C0DE0, 32'($urandom())};
      bus.req_addr[64*i +: 64] = ch_addr[i];
    end
  endtask

  // Predict this cycle's grant from start-of-cycle model state, then advance.
  task automatic model_step(input vec_t v, output logic [3:0] exp_ready);
    bit   slot;
    bit   anyf;
    bit   live;
    int   grant;
    int   tg;
    int   tag;
    req_t rec;
    slot  = !m_txv || v.tx_ready;
    anyf  = (m_count > 0);
    grant = -1;
    if (slot) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if (grant < 0 && v.valid[c] && (!v.is_read[c] || anyf)) grant = c;
      end
    end
    exp_ready = (grant >= 0) ? 4'(1 << grant) : 4'h0;
    tg   = int'(v.cpl_tag);
    live = (tg < NTAG) ? !m_free[tg] : 1'b0;
    if (m_txv && v.tx_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (grant >= 0) begin
      tag = 0;
      if (v.is_read[grant]) begin
        tag = -1;
        for (int i = 0; i < NTAG; i++) if (tag < 0 && m_free[i]) tag = i;
        m_free[tag]   = 0;
        m_owner[tag]  = grant;
        m_count--;
      end
      rec.is_read = v.is_read[grant];
      rec.addr    = ch_addr[grant];
      rec.chan    = 3'(grant);
      rec.tag     = 8'(tag);
      exp_q.push_back(rec);
      m_last = grant;
      m_txv  = 1;
    end else if (v.tx_ready) begin
      m_txv = 0;
    end
    m_rv = v.cpl_valid && live;
    if (m_rv) m_rc = m_owner[tg];
    if (v.cpl_valid && !live) m_err = 1;
    if (m_rv && v.cpl_last) begin
      m_free[tg] = 1;
      m_count++;
    end
  endtask

  task automatic checkOutput();
    check("tx_valid", 64'(bus.tx_valid), 64'(m_txv));
    if (m_txv) begin
      if (exp_q.size() == 0) begin
        check("tx_expected_record", 64'(bus.tx_valid), 64'h0);
      end else begin
        check("tx_is_read", 64'(bus.tx_is_read), 64'(exp_q[0].is_read));
        check("tx_addr", bus.tx_addr, exp_q[0].addr);
        check("tx_tag", 64'(bus.tx_tag), 64'(exp_q[0].tag));
        check("tx_chan", 64'(bus.tx_chan), 64'(exp_q[0].chan));
      end
    end
    check("tags_free", 64'(bus.tags_free), 64'(m_count));
    check("cpl_route_valid", 64'(bus.cpl_route_valid), 64'(m_rv));
    if (m_rv) check("cpl_route_chan", 64'(bus.cpl_route_chan), 64'(m_rc));
    check("err_spurious_cpl", 64'(bus.err_spurious_cpl), 64'(m_err));
  endtask

  task automatic applyStimulus(input vec_t v, output logic [3:0] got_ready);
    logic [3:0] er;
    @(negedge clock);
    drive(v);
    #1;
    model_step(v, er);
    check("req_ready_model", 64'(bus.req_ready), 64'(er));
    got_ready = bus.req_ready;
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // All four channels writing, then a 5-cycle stall, then mixed patterns.
    tbl[0]  = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b0001);
    tbl[1]  = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b0010);
    tbl[2]  = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b0100);
    tbl[3]  = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b1000);
    tbl[4]  = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b0001);
    tbl[5]  = mkv(4'hF, 4'h0, 0, 0, 0, 0, 4'b0000);
    tbl[6]  = mkv(4'hF, 4'h0, 0, 0, 0, 0, 4'b0000);
    tbl[7]  = mkv(4'hF, 4'h0, 0, 0, 0, 0, 4'b0000);
    tbl[8]  = mkv(4'hF, 4'h0, 0, 0, 0, 0, 4'b0000);
    tbl[9]  = mkv(4'hF, 4'h0, 0, 0, 0, 0, 4'b0000);
    tbl[10] = mkv(4'hF, 4'h0, 1, 0, 0, 0, 4'b0010);
    tbl[11] = mkv(4'h5, 4'h0, 1, 0, 0, 0, 4'b0100);
    tbl[12] = mkv(4'h5, 4'h0, 1, 0, 0, 0, 4'b0001);
    tbl[13] = mkv(4'h0, 4'h0, 1, 0, 0, 0, 4'b0000);
    tbl[14] = mkv(4'h0, 4'h0, 1, 0, 0, 0, 4'b0000);

    // Reset values, with requests pending so req_ready gating is visible.
    pci_reset_n = 1'b0;
    model_reset();
    drive(mkv(4'hF, 4'h0, 1, 0, 0, 0, 0));
    @(negedge clock);
    #1;
    check("reset_req_ready", 64'(bus.req_ready), 64'h0);
    check("reset_tx_valid", 64'(bus.tx_valid), 64'h0);
    check("reset_tx_addr", bus.tx_addr, 64'h0);
    check("reset_tx_tag", 64'(bus.tx_tag), 64'h0);
    check("reset_tags_free", 64'(bus.tags_free), 64'd32);
    check("reset_err", 64'(bus.err_spurious_cpl), 64'h0);
    check("reset_route_valid", 64'(bus.cpl_route_valid), 64'h0);
    drive(mkv(4'h0, 4'h0, 1, 0, 0, 0, 0));
    @(negedge clock);
    pci_reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i], r);
      check($sformatf("tbl%0d_req_ready", i), 64'(r), 64'(tbl[i].exp_ready));
    end

    // Channel 1 drains the pool with 32 reads.
    for (int t = 0; t < NTAG; t++) begin
      applyStimulus(mkv(4'b0010, 4'b0010, 1, 0, 0, 0, 0), r);
      check($sformatf("read%0d_tag", t), 64'(bus.tx_tag), 64'(t));
    end
    check("pool_empty", 64'(bus.tags_free), 64'h0);

    // Empty pool: channel 1 starves, channel 2 writes still flow.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkv(4'b0110, 4'b0010, 1, 0, 0, 0, 0), r);
      check("starved_read_ready", 64'(r), 64'b0100);
    end

    // Tag 5: partial completion, then final completion with a read waiting.
    applyStimulus(mkv(4'b0000, 4'b0000, 1, 1, 8'd5, 0, 0), r);
    check("cpl5_partial_chan", 64'(bus.cpl_route_chan), 64'd1);
    check("cpl5_partial_free", 64'(bus.tags_free), 64'd0);
    applyStimulus(mkv(4'b0010, 4'b0010, 1, 1, 8'd5, 1, 0), r);
    check("cpl5_same_cycle_ready", 64'(r), 64'b0000);
    check("cpl5_last_chan", 64'(bus.cpl_route_chan), 64'd1);
    check("cpl5_last_free", 64'(bus.tags_free), 64'd1);
    applyStimulus(mkv(4'b0010, 4'b0010, 1, 0, 0, 0, 0), r);
    check("realloc_ready", 64'(r), 64'b0010);
    check("realloc_tag", 64'(bus.tx_tag), 64'd5);

    // Free tag 7, then hit it again and an out-of-range tag: spurious, sticky.
    applyStimulus(mkv(4'b0000, 4'b0000, 1, 1, 8'd7, 1, 0), r);
    check("cpl7_route_valid", 64'(bus.cpl_route_valid), 64'd1);
    applyStimulus(mkv(4'b0000, 4'b0000, 1, 1, 8'd7, 1, 0), r);
    check("spurious7_route_valid", 64'(bus.cpl_route_valid), 64'd0);
    check("spurious7_err", 64'(bus.err_spurious_cpl), 64'd1);
    check("spurious7_free", 64'(bus.tags_free), 64'd1);
    applyStimulus(mkv(4'b0000, 4'b0000, 1, 1, 8'd40, 1, 0), r);
    check("spurious40_route_valid", 64'(bus.cpl_route_valid), 64'd0);
    applyStimulus(mkv(4'b0000, 4'b0000, 1, 0, 0, 0, 0), r);
    check("err_sticky", 64'(bus.err_spurious_cpl), 64'd1);

    // Reset in the middle of a write burst.
    applyStimulus(mkv(4'hF, 4'h0, 1, 0, 0, 0, 0), r);
    applyStimulus(mkv(4'hF, 4'h0, 1, 0, 0, 0, 0), r);
    @(negedge clock);
    #2;
    pci_reset_n = 1'b0;
    #1;
    check("midreset_tx_valid", 64'(bus.tx_valid), 64'h0);
    check("midreset_req_ready", 64'(bus.req_ready), 64'h0);
    check("midreset_tags_free", 64'(bus.tags_free), 64'd32);
    check("midreset_err", 64'(bus.err_spurious_cpl), 64'h0);
    model_reset();
    drive(mkv(4'h0, 4'h0, 1, 0, 0, 0, 0));
    @(negedge clock);
    pci_reset_n = 1'b1;
    applyStimulus(mkv(4'hF, 4'h0, 1, 0, 0, 0, 0), r);
    check("post_reset_first_grant", 64'(r), 64'b0001);
    check("post_reset_tx_chan", 64'(bus.tx_chan), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
